mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter BURST, default 8, number of 16-bit words returned per read request (1..64).
REQ-002 SHALL have parameter AW, default 10, internal array address width; array depth is 2^AW words.
REQ-003 SHALL have parameter WAIT, default 1, idle cycles between req sampled high and ack (0..15).
REQ-004 SHALL have parameter LATENCY, default 2, cycles from ack of a read to the first valid (1..15).
REQ-005 SHALL have port clkSYS  in  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port addr  in  24  word address, sampled with req.
REQ-008 SHALL have port data  in  16  write data, sampled with req when wr=1.
REQ-009 SHALL have port req  in  1  request, held high by the initiator until ack.
REQ-010 SHALL have port wr  in  1  1=write, 0=read; valid only while req=1.
REQ-011 SHALL have port ack  out  1  one-cycle accept pulse.
REQ-012 SHALL have port mem  out  16  read data word.
REQ-013 SHALL have port valid  out  1  mem holds a read word this cycle.
REQ-014 SHALL have port oor  out  1  sticky flag: a request had addr[23:AW] nonzero.

Function
REQ-015 SHALL implement states Idle, Wait, Accept, Latency, Burst.
REQ-016 Idle: req=1 -> Wait with a WAIT counter loaded; WAIT=0 goes directly to Accept.
REQ-017 Wait: counter decrements each cycle; at zero -> Accept; req dropping in Wait -> Idle, no ack, no side effect.
REQ-018 Accept: ack=1 for exactly one cycle; addr, data and wr are captured in this cycle.
REQ-019 Write accept: array[addr[AW-1:0]] <= data at the Accept edge; next state Idle.
REQ-020 Read accept: next state Latency; the first word appears LATENCY cycles after the ack cycle.
REQ-021 Burst: valid=1 for BURST consecutive cycles, word i = array[(addr+i) mod 2^AW], i=0..BURST-1; then Idle.
REQ-022 Address wrap at 2^AW SHALL be silent; the upper address bits are ignored for access.
REQ-023 oor SHALL set on any Accept with addr[23:AW]!=0 and clear only on reset.
REQ-024 Requests during Latency/Burst SHALL NOT be acked; they are serviced from Idle after the burst.
REQ-025 At least one Idle cycle SHALL follow every ack, so a req still high in the cycle after ack is never double-accepted.
REQ-026 mem SHALL be 0 whenever valid=0.
REQ-027 A write followed by a read of the same address SHALL return the written data.

Reset
REQ-028 reset SHALL immediately force ack=0, valid=0, mem=0 and oor=0, and set the state to Idle, including mid-burst.
REQ-029 Array contents SHALL NOT be reset; reads of never-written words are undefined.
REQ-030 No ack or valid SHALL occur before req is sampled after reset deasserts.

Structure
REQ-031 Package mem_pkg SHALL hold the state enum, ADDR_W=24 and DATA_W=16, shared with the memory initiators.
REQ-032 Sub-module mem_responder_ram SHALL provide a single-port 2^AW x 16 synchronous RAM with one-cycle read latency; the read pipeline SHALL compensate so that REQ-020 holds.

Verification
REQ-033 Write addr=0x000010, data=0xA5C3, then read with BURST=8 -> first valid word 0xA5C3, exactly 8 valid cycles.
REQ-034 WAIT=3, LATENCY=2, read request -> ack 4 cycles after req rises; first valid 2 cycles after the ack.
REQ-035 Read at addr=0x0003FE, AW=10, after writes 0x1111..0x8888 to 0x3FE,0x3FF,0x000..0x005 -> words returned in that wrapped order.
REQ-036 Write addr=0x012345 -> oor=1 and array[0x345] is updated; oor stays 1 until reset.
REQ-037 Assert reset at the 3rd valid of a burst -> valid=0 and mem=0 in the same cycle; the next request is serviced normally.
REQ-038 Hold req=1 through an entire burst -> no ack during the burst; ack WAIT+1 cycles after the burst ends.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder and its initiators.
package mem_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCEPT,
    S_LATENCY,
    S_BURST
  } state_t;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous RAM, 2^AW x DATA_W, one-cycle read latency (read-first).
module mem_responder_ram
  import mem_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] array [0:(1<<AW)-1];

  // Write on we, always register the addressed word for the next cycle.
  always_ff @(posedge clk) begin
    if (we) array[addr] <= wdata;
    rdata <= array[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Request/ack memory responder: single writes, fixed-length wrapped read bursts.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned BURST   = 8,
  parameter int unsigned AW      = 10,
  parameter int unsigned WAIT    = 1,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clkSYS,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              req,
  input  logic              wr,
  output logic              ack,
  output logic [DATA_W-1:0] mem,
  output logic              valid,
  output logic              oor
);

  localparam logic [6:0]    WAIT_LD  = 7'(WAIT - 1);
  localparam logic [6:0]    LAT_LD   = 7'(LATENCY - 2);
  localparam logic [6:0]    BURST_LD = 7'(BURST - 1);
  // The RAM needs its address one cycle before the word is shown; with
  // LATENCY=1 the Accept cycle itself issues word 0, so the pointer starts at word 1.
  localparam logic [AW-1:0] PTR_SKIP = (LATENCY == 1) ? AW'(1) : '0;

  state_t            state, state_nx;
  logic [6:0]        cnt, cnt_nx;
  logic [AW-1:0]     ptr, ptr_nx;
  logic              post_ack;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_q;

  mem_responder_ram #(.AW(AW)) u_ram (
    .clk   (clkSYS),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (data),
    .rdata (ram_q)
  );

  // State, shared counter, read pointer and post-ack guard registers.
  always_ff @(posedge clkSYS or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ptr      <= '0;
      post_ack <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      ptr      <= ptr_nx;
      post_ack <= (state == S_ACCEPT);
    end
  end

  // Sticky out-of-range flag on any accepted request with upper address bits set.
  always_ff @(posedge clkSYS or posedge reset) begin
    if (reset) begin
      oor <= 1'b0;
    end else if (state == S_ACCEPT && addr[ADDR_W-1:AW] != '0) begin
      oor <= 1'b1;
    end
  end

  // Next-state, counter, RAM port and handshake decode.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ptr_nx   = ptr;
    ack      = 1'b0;
    valid    = 1'b0;
    ram_we   = 1'b0;
    ram_addr = ptr;
    case (state)
      S_IDLE: begin
        if (req && !post_ack) begin
          if (WAIT == 0) begin
            state_nx = S_ACCEPT;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = WAIT_LD;
          end
        end
      end
      S_WAIT: begin
        if (!req)            state_nx = S_IDLE;
        else if (cnt == '0)  state_nx = S_ACCEPT;
        else                 cnt_nx   = cnt - 7'd1;
      end
      S_ACCEPT: begin
        ack      = 1'b1;
        ram_addr = addr[AW-1:0];
        ram_we   = wr;
        if (wr) begin
          state_nx = S_IDLE;
        end else begin
          ptr_nx = addr[AW-1:0] + PTR_SKIP;
          if (LATENCY == 1) begin
            state_nx = S_BURST;
            cnt_nx   = BURST_LD;
          end else begin
            state_nx = S_LATENCY;
            cnt_nx   = LAT_LD;
          end
        end
      end
      S_LATENCY: begin
        // Last latency cycle issues word 0 to the RAM.
        if (cnt == '0) begin
          ptr_nx   = ptr + AW'(1);
          state_nx = S_BURST;
          cnt_nx   = BURST_LD;
        end else begin
          cnt_nx = cnt - 7'd1;
        end
      end
      S_BURST: begin
        valid  = 1'b1;
        ptr_nx = ptr + AW'(1);
        if (cnt == '0) state_nx = S_IDLE;
        else           cnt_nx   = cnt - 7'd1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Read data is forced to zero outside burst cycles.
  always_comb begin
    mem = valid ? ram_q : '0;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (WAIT=3, LATENCY=2, BURST=8, AW=10).
module tb_mem_responder;

  logic        clkSYS = 1'b0;
  logic        reset  = 1'b1;
  logic [23:0] addr   = '0;
  logic [15:0] data   = '0;
  logic        req    = 1'b0;
  logic        wr     = 1'b0;
  logic        ack;
  logic [15:0] mem;
  logic        valid;
  logic        oor;

  int checks = 0;
  int errors = 0;

  logic [15:0] words [0:79];
  int          nwords;
  int          ack_lat;
  int          val_lat;

  always #5 clkSYS = ~clkSYS;

  mem_responder #(.BURST(8), .AW(10), .WAIT(3), .LATENCY(2)) dut (
    .clkSYS (clkSYS),
    .reset  (reset),
    .addr   (addr),
    .data   (data),
    .req    (req),
    .wr     (wr),
    .ack    (ack),
    .mem    (mem),
    .valid  (valid),
    .oor    (oor)
  );

  // Raise req after two idle negedges; ack_lat = negedges from raise to ack (-1 on timeout).
  task automatic issue(input logic [23:0] a, input logic [15:0] d, input logic w, input int hold);
    @(negedge clkSYS);
    @(negedge clkSYS);
    addr = a; data = d; wr = w; req = 1'b1;
    ack_lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clkSYS);
      if (ack) begin
        ack_lat = n;
        break;
      end
    end
    for (int n = 0; n < hold; n++) @(negedge clkSYS);
    req = 1'b0;
  endtask

  // From the ack negedge: val_lat = negedges to first valid, then capture the burst.
  task automatic collect();
    nwords  = 0;
    val_lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clkSYS);
      if (valid) begin
        val_lat = n;
        break;
      end
    end
    while (valid && nwords < 70) begin
      words[nwords] = mem;
      nwords++;
      @(negedge clkSYS);
    end
  endtask

  task automatic test_reset();
    int events;
    repeat (2) @(negedge clkSYS);
    checks++; if (ack !== 1'b0)    begin errors++; $display("FAIL reset_ack got %b expected 0", ack); end
    checks++; if (valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %b expected 0", valid); end
    checks++; if (mem !== 16'h0)   begin errors++; $display("FAIL reset_mem got %h expected 0000", mem); end
    checks++; if (oor !== 1'b0)    begin errors++; $display("FAIL reset_oor got %b expected 0", oor); end
    reset = 1'b0;
    events = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clkSYS);
      if (ack !== 1'b0 || valid !== 1'b0) events++;
    end
    checks++; if (events != 0) begin errors++; $display("FAIL idle_after_reset got %0d events expected 0", events); end
  endtask

  task automatic test_write_read();
    int extra;
    issue(24'h000010, 16'hA5C3, 1'b1, 2);
    checks++; if (ack_lat != 4) begin errors++; $display("FAIL write_ack_latency got %0d expected 4", ack_lat); end
    extra = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clkSYS);
      if (ack) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL double_accept got %0d acks expected 0", extra); end
    issue(24'h000010, 16'h0000, 1'b0, 0);
    checks++; if (ack_lat != 4) begin errors++; $display("FAIL read_ack_latency got %0d expected 4", ack_lat); end
    collect();
    checks++; if (val_lat != 2)       begin errors++; $display("FAIL first_valid_latency got %0d expected 2", val_lat); end
    checks++; if (words[0] !== 16'hA5C3) begin errors++; $display("FAIL write_read_word got %h expected a5c3", words[0]); end
    checks++; if (nwords != 8)        begin errors++; $display("FAIL burst_length got %0d expected 8", nwords); end
    checks++; if (mem !== 16'h0)      begin errors++; $display("FAIL mem_after_burst got %h expected 0000", mem); end
  endtask

  task automatic test_wrap();
    logic [9:0]  wa [0:7];
    logic [15:0] exp;
    wa[0] = 10'h3FE; wa[1] = 10'h3FF;
    for (int k = 2; k < 8; k++) wa[k] = 10'(k - 2);
    for (int k = 0; k < 8; k++) begin
      exp = 16'(16'h1111 * (k + 1));
      issue({14'h0, wa[k]}, exp, 1'b1, 0);
    end
    issue(24'h0003FE, 16'h0000, 1'b0, 0);
    collect();
    checks++; if (nwords != 8) begin errors++; $display("FAIL wrap_length got %0d expected 8", nwords); end
    for (int i = 0; i < 8; i++) begin
      exp = 16'(16'h1111 * (i + 1));
      checks++;
      if (words[i] !== exp) begin errors++; $display("FAIL wrap_word%0d got %h expected %h", i, words[i], exp); end
    end
  endtask

  task automatic test_wait_drop();
    int acks;
    @(negedge clkSYS);
    @(negedge clkSYS);
    addr = 24'h0003FE; data = 16'hDEAD; wr = 1'b1; req = 1'b1;
    acks = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clkSYS);
      if (ack) acks++;
      if (n == 2) req = 1'b0;
    end
    checks++; if (acks != 0) begin errors++; $display("FAIL wait_drop_ack got %0d expected 0", acks); end
    issue(24'h0003FE, 16'h0000, 1'b0, 0);
    collect();
    checks++; if (words[0] !== 16'h1111) begin errors++; $display("FAIL wait_drop_side_effect got %h expected 1111", words[0]); end
  endtask

  task automatic test_oor();
    checks++; if (oor !== 1'b0) begin errors++; $display("FAIL oor_before got %b expected 0", oor); end
    issue(24'h012345, 16'hBEEF, 1'b1, 0);
    @(negedge clkSYS);
    checks++; if (oor !== 1'b1) begin errors++; $display("FAIL oor_set got %b expected 1", oor); end
    issue(24'h000345, 16'h0000, 1'b0, 0);
    collect();
    checks++; if (words[0] !== 16'hBEEF) begin errors++; $display("FAIL oor_low_write got %h expected beef", words[0]); end
    checks++; if (oor !== 1'b1) begin errors++; $display("FAIL oor_sticky got %b expected 1", oor); end
  endtask

  task automatic test_back_to_back();
    int acks_in_burst;
    int nb;
    int lat;
    @(negedge clkSYS);
    @(negedge clkSYS);
    addr = 24'h000000; wr = 1'b0; req = 1'b1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clkSYS);
      if (ack) begin lat = n; break; end
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL b2b_first_ack got %0d expected 4", lat); end
    acks_in_burst = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clkSYS);
      if (ack) acks_in_burst++;
      if (valid) break;
    end
    nb = 0;
    while (valid && nb < 70) begin
      if (ack) acks_in_burst++;
      nb++;
      @(negedge clkSYS);
    end
    checks++; if (acks_in_burst != 0) begin errors++; $display("FAIL b2b_ack_in_burst got %0d expected 0", acks_in_burst); end
    checks++; if (nb != 8) begin errors++; $display("FAIL b2b_burst_length got %0d expected 8", nb); end
    lat = -1;
    if (ack) lat = 0;
    else begin
      for (int n = 1; n <= 40; n++) begin
        @(negedge clkSYS);
        if (ack) begin lat = n; break; end
      end
    end
    req = 1'b0;
    checks++; if (lat != 4) begin errors++; $display("FAIL b2b_second_ack got %0d expected 4", lat); end
    collect();
    checks++; if (words[0] !== 16'h3333) begin errors++; $display("FAIL b2b_second_word got %h expected 3333", words[0]); end
  endtask

  task automatic test_reset_mid_burst();
    int seen;
    issue(24'h0003FE, 16'h0000, 1'b0, 0);
    seen = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clkSYS);
      if (valid) seen++;
      if (seen == 3) break;
    end
    checks++; if (mem !== 16'h3333 || valid !== 1'b1) begin errors++; $display("FAIL third_word got %h/%b expected 3333/1", mem, valid); end
    reset = 1'b1;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midburst_valid got %b expected 0", valid); end
    checks++; if (mem !== 16'h0)  begin errors++; $display("FAIL midburst_mem got %h expected 0000", mem); end
    checks++; if (oor !== 1'b0)   begin errors++; $display("FAIL midburst_oor got %b expected 0", oor); end
    @(negedge clkSYS);
    @(negedge clkSYS);
    reset = 1'b0;
    issue(24'h0003FE, 16'h0000, 1'b0, 0);
    checks++; if (ack_lat != 4) begin errors++; $display("FAIL post_reset_ack got %0d expected 4", ack_lat); end
    collect();
    checks++; if (nwords != 8) begin errors++; $display("FAIL post_reset_length got %0d expected 8", nwords); end
    checks++; if (words[0] !== 16'h1111) begin errors++; $display("FAIL post_reset_word0 got %h expected 1111", words[0]); end
    checks++; if (words[7] !== 16'h8888) begin errors++; $display("FAIL post_reset_word7 got %h expected 8888", words[7]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_wait_drop();
    test_oor();
    test_back_to_back();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
